// File: rtl/sc_cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// sc_cpu_step_ctrl
//
// Run/halt/single-step sequencer for the single-cycle RISC-V computer.
// Replaces the free-running memory clocks with one-cycle enables.
//
// Each instruction is four slots of DIV system cycles each:
//   - fetch strobe at the first cycle of slot 0
//   - data strobe at slot 2
//   - commit strobe at slot 3
//
// Also provides:
//   - a PC breakpoint
//   - a retired-instruction counter for the segment display
//
// Ports
//   sys_clk_in   in   1   system clock (only clock)
//   sys_rst      in   1   asynchronous active-high reset
//   run_sw       in   1   raw run switch (1 = run)
//   step_btn     in   1   raw single-step pushbutton
//   bp_en        in   1   breakpoint enable
//   bp_addr      in   32  breakpoint PC
//   pc           in   32  current PC from the CPU
//   imem_clk_en  out  1   instruction fetch strobe
//   dmem_clk_en  out  1   data memory strobe
//   cpu_clk_en   out  1   PC/regfile commit strobe
//   halted       out  1   sequencer is in HALT or BREAK
//   at_break     out  1   sequencer is in BREAK
//   inst_count   out  32  retired instruction count (wraps)
// ---------------------------------------------------------------------------
module sc_cpu_step_ctrl #(
    parameter int DIV        = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        imem_clk_en,
    output logic        dmem_clk_en,
    output logic        cpu_clk_en,
    output logic        halted,
    output logic        at_break,
    output logic [31:0] inst_count
);

    localparam int INST_CYCLES = 4 * DIV;
    localparam int PW          = $clog2(INST_CYCLES);
    localparam int DW          = $clog2(DEB_CYCLES + 1);

    localparam logic [PW-1:0] PHASE_IMEM = '0;
    localparam logic [PW-1:0] PHASE_DMEM = PW'(2 * DIV);
    localparam logic [PW-1:0] PHASE_CPU  = PW'(3 * DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(INST_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    logic          run_meta;
    logic          run_s;
    logic          btn_meta;
    logic          btn_s;
    logic          btn_level;
    logic [DW-1:0] deb_cnt;
    logic          step_p;

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic          busy;
    logic [PW-1:0] phase;
    logic          skip_bp;
    logic [31:0]   inst_count_q;

    logic          last_cycle;
    logic          issue_pt;
    logic          bp_hit;
    logic          issue;
    logic          leave_break;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            run_meta <= run_sw;
            run_s    <= run_meta;
            btn_meta <= step_btn;
            btn_s    <= btn_meta;
        end
    end

    // The accepted button level only changes after DEB_CYCLES consecutive
    // samples disagree with it. Any agreeing sample restarts the count.
    // A press is reported as a one-cycle step_p on an accepted 0->1 change.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            btn_level <= 1'b0;
            deb_cnt   <= '0;
            step_p    <= 1'b0;
        end else begin
            step_p <= 1'b0;
            if (btn_s == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_level <= btn_s;
                deb_cnt   <= '0;
                step_p    <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // An issue point is any cycle after which a fresh slot 0 could start:
    // either nothing is in flight or this is the last cycle of the
    // current instruction.
    assign last_cycle = busy && (phase == PHASE_LAST);
    assign issue_pt   = !busy || last_cycle;
    assign bp_hit     = bp_en && (pc == bp_addr) && !skip_bp;

    // Sequencer decisions.
    // RUN only re-evaluates at issue points, so dropping the run switch
    // never cuts an instruction short. STEP issues once from idle, then
    // returns to HALT when that instruction's last cycle is reached.
    always_comb begin
        state_n     = state;
        issue       = 1'b0;
        leave_break = 1'b0;
        case (state)
            S_HALT: begin
                if (run_s) begin
                    state_n = S_RUN;
                end else if (step_p) begin
                    state_n = S_STEP;
                end
            end
            S_RUN: begin
                if (issue_pt) begin
                    if (!run_s) begin
                        state_n = S_HALT;
                    end else if (bp_hit) begin
                        state_n = S_BREAK;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (!busy) begin
                    issue = 1'b1;
                end else if (last_cycle) begin
                    state_n = S_HALT;
                end
            end
            S_BREAK: begin
                if (step_p) begin
                    state_n     = S_STEP;
                    leave_break = 1'b1;
                end else if (!run_s) begin
                    state_n     = S_HALT;
                    leave_break = 1'b1;
                end
            end
            default: state_n = S_HALT;
        endcase
    end

    // State, instruction phase, and breakpoint-skip bookkeeping.
    // skip_bp lets the instruction that hit the breakpoint run once on
    // resume. It clears as soon as that resumed instruction is issued.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= S_HALT;
            busy    <= 1'b0;
            phase   <= '0;
            skip_bp <= 1'b0;
        end else begin
            state <= state_n;
            if (issue) begin
                busy  <= 1'b1;
                phase <= '0;
            end else if (last_cycle) begin
                busy  <= 1'b0;
                phase <= '0;
            end else if (busy) begin
                phase <= phase + PW'(1);
            end
            if (issue) begin
                skip_bp <= 1'b0;
            end else if (leave_break) begin
                skip_bp <= 1'b1;
            end
        end
    end

    // The counter bumps on the edge that ends the commit cycle, so the new
    // value is visible in the cycle after cpu_clk_en.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            inst_count_q <= '0;
        end else if (cpu_clk_en) begin
            inst_count_q <= inst_count_q + 32'd1;
        end
    end

    // Strobes are decoded from flops only.
    // busy is low in HALT and BREAK, so those states can never pulse.
    assign imem_clk_en = busy && (phase == PHASE_IMEM);
    assign dmem_clk_en = busy && (phase == PHASE_DMEM);
    assign cpu_clk_en  = busy && (phase == PHASE_CPU);
    assign halted      = (state == S_HALT) || (state == S_BREAK);
    assign at_break    = (state == S_BREAK);
    assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_sc_cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_cpu_step_ctrl
//
// Self-checking bench for sc_cpu_step_ctrl with DIV=2, DEB_CYCLES=4.
//
// A tiny CPU stand-in advances pc by 4 on every commit strobe.
//
// A monitor logs the cycle number of every strobe.
//
// Expected results come from the sequencing rules themselves:
//   - a run started at cycle c0 fetches at c0+4+8k;
//   - data strobe is +4 and commit strobe is +6 after each fetch;
//   - a run dropped at cycle d still issues every fetch with T0 <= d+2.
// ---------------------------------------------------------------------------
module tb_sc_cpu_step_ctrl;

    localparam int DIV        = 2;
    localparam int DEB_CYCLES = 4;
    localparam int INST       = 4 * DIV;

    logic        sys_clk_in = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        run_sw     = 1'b0;
    logic        step_btn   = 1'b0;
    logic        bp_en      = 1'b0;
    logic [31:0] bp_addr    = 32'h0;
    logic [31:0] pc;
    logic        imem_clk_en;
    logic        dmem_clk_en;
    logic        cpu_clk_en;
    logic        halted;
    logic        at_break;
    logic [31:0] inst_count;

    int tests_run  = 0;
    int fail_count = 0;

    int cycle         = 0;
    int imem_q[$];
    int dmem_q[$];
    int cpu_q[$];
    int overlap_err   = 0;
    int halt_pulse_err = 0;

    int model_count;
    int c0;
    int d;
    int n;
    int expected;
    int bi;
    int bd;
    int bc;

    sc_cpu_step_ctrl #(
        .DIV        (DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .sys_clk_in  (sys_clk_in),
        .sys_rst     (sys_rst),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .imem_clk_en (imem_clk_en),
        .dmem_clk_en (dmem_clk_en),
        .cpu_clk_en  (cpu_clk_en),
        .halted      (halted),
        .at_break    (at_break),
        .inst_count  (inst_count)
    );

    // 100 MHz system clock.
    always #5 sys_clk_in = ~sys_clk_in;

    // Cycle number = count of rising edges seen so far.
    always @(posedge sys_clk_in) cycle <= cycle + 1;

    // Stand-in CPU: the PC advances by one word on every commit.
    always @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) pc <= 32'h0;
        else if (cpu_clk_en) pc <= pc + 32'd4;
    end

    // Strobe logger and global invariants, sampled mid-cycle.
    always @(negedge sys_clk_in) begin
        if (!sys_rst) begin
            if (imem_clk_en) imem_q.push_back(cycle);
            if (dmem_clk_en) dmem_q.push_back(cycle);
            if (cpu_clk_en)  cpu_q.push_back(cycle);
            if (int'(imem_clk_en) + int'(dmem_clk_en) + int'(cpu_clk_en) > 1)
                overlap_err++;
            if (halted && (imem_clk_en || dmem_clk_en || cpu_clk_en))
                halt_pulse_err++;
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expect_val);
        tests_run++;
        if (actual !== expect_val) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expect_val);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(negedge sys_clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic run_val, input logic btn_val, input int cycles);
        run_sw   = run_val;
        step_btn = btn_val;
        tick(cycles);
    endtask

    // Number of instructions a run raised at c0 and dropped at d issues.
    function automatic int issuedBy(input int start_c, input int drop_c);
        if (drop_c + 2 < start_c + 4) return 0;
        return (drop_c + 2 - (start_c + 4)) / INST + 1;
    endfunction

    initial begin
        // ---- 1: reset and idle ----
        tick(3);
        checkOutput("t1_halted_in_reset", 32'(halted), 32'd1);
        sys_rst = 1'b0;
        tick(100);
        checkOutput("t1_no_imem", 32'(imem_q.size()), 32'd0);
        checkOutput("t1_no_dmem", 32'(dmem_q.size()), 32'd0);
        checkOutput("t1_no_cpu", 32'(cpu_q.size()), 32'd0);
        checkOutput("t1_halted", 32'(halted), 32'd1);
        checkOutput("t1_at_break", 32'(at_break), 32'd0);
        checkOutput("t1_count", inst_count, 32'd0);

        // ---- 2: free run, ten instructions ----
        c0 = cycle;
        run_sw = 1'b1;
        n = 0;
        while (cpu_q.size() < 10 && n < 300) begin
            tick(1);
            n++;
        end
        checkOutput("t2_ten_commits_seen", 32'(cpu_q.size() >= 10), 32'd1);
        tick(1);
        checkOutput("t2_count_10", inst_count, 32'd10);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("t2_imem%0d", k), imem_q[k], c0 + 4 + INST * k);
            checkOutput($sformatf("t2_dmem%0d", k), dmem_q[k], c0 + 4 + INST * k + 2 * DIV);
            checkOutput($sformatf("t2_cpu%0d", k), cpu_q[k], c0 + 4 + INST * k + 3 * DIV);
        end
        d = cycle;
        run_sw = 1'b0;
        model_count = issuedBy(c0, d);
        tick(2 * INST + 6);
        checkOutput("t2_halted_after_drop", 32'(halted), 32'd1);
        checkOutput("t2_issued_total", 32'(imem_q.size()), model_count);
        checkOutput("t2_count_total", inst_count, model_count);

        // ---- randomized run windows ----
        for (int t = 0; t < 6; t++) begin
            tick($urandom_range(3, 9));
            bi = imem_q.size();
            bd = dmem_q.size();
            bc = cpu_q.size();
            c0 = cycle;
            run_sw = 1'b1;
            tick($urandom_range(1, 60));
            d = cycle;
            run_sw = 1'b0;
            expected = issuedBy(c0, d);
            tick(2 * INST + 6);
            model_count += expected;
            checkOutput($sformatf("rnd%0d_imem", t), imem_q.size() - bi, expected);
            checkOutput($sformatf("rnd%0d_dmem", t), dmem_q.size() - bd, expected);
            checkOutput($sformatf("rnd%0d_cpu", t), cpu_q.size() - bc, expected);
            checkOutput($sformatf("rnd%0d_count", t), inst_count, model_count);
            checkOutput($sformatf("rnd%0d_halted", t), 32'(halted), 32'd1);
            if (expected > 0) begin
                checkOutput($sformatf("rnd%0d_first_fetch", t), imem_q[bi], c0 + 4);
                checkOutput($sformatf("rnd%0d_last_commit", t), cpu_q[bc + expected - 1],
                            c0 + 4 + INST * (expected - 1) + 3 * DIV);
            end
        end

        // ---- 3: debounced single step ----
        bi = imem_q.size();
        for (int g = 0; g < 4; g++) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(1, DEB_CYCLES - 1));
            applyStimulus(1'b0, 1'b0, $urandom_range(1, 4));
        end
        tick(20);
        checkOutput("t3_glitches_ignored", imem_q.size() - bi, 32'd0);
        bi = imem_q.size();
        bd = dmem_q.size();
        bc = cpu_q.size();
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 30);
        model_count += 1;
        checkOutput("t3_one_imem", imem_q.size() - bi, 32'd1);
        checkOutput("t3_one_dmem", dmem_q.size() - bd, 32'd1);
        checkOutput("t3_one_cpu", cpu_q.size() - bc, 32'd1);
        checkOutput("t3_count", inst_count, model_count);
        checkOutput("t3_halted", 32'(halted), 32'd1);
        bi = imem_q.size();
        applyStimulus(1'b0, 1'b1, DEB_CYCLES);
        applyStimulus(1'b0, 1'b0, 30);
        model_count += 1;
        checkOutput("t3_exact_deb_press", imem_q.size() - bi, 32'd1);
        checkOutput("t3_exact_deb_count", inst_count, model_count);

        // ---- 4: breakpoint, step out of BREAK, resume past it ----
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(2);
        bp_en = 1'b1;
        bp_addr = 32'h10;
        bi = imem_q.size();
        run_sw = 1'b1;
        n = 0;
        while (!at_break && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("t4_at_break", 32'(at_break), 32'd1);
        checkOutput("t4_halted", 32'(halted), 32'd1);
        checkOutput("t4_count_before_bp", inst_count, 32'd4);
        tick(20);
        checkOutput("t4_no_fetch_in_break", imem_q.size() - bi, 32'd4);
        checkOutput("t4_pc_at_bp", pc, 32'h10);
        step_btn = 1'b1;
        n = 0;
        while (at_break && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("t4_left_break", 32'(at_break), 32'd0);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 30);
        checkOutput("t4_step_fetches", imem_q.size() - bi, 32'd5);
        checkOutput("t4_step_count", inst_count, 32'd5);
        checkOutput("t4_step_pc", pc, 32'h14);
        checkOutput("t4_step_halted", 32'(halted), 32'd1);
        bp_addr = 32'h1C;
        run_sw = 1'b1;
        n = 0;
        while (!at_break && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("t4_second_break", 32'(at_break), 32'd1);
        checkOutput("t4_second_count", inst_count, 32'd7);
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("t4_break_to_halt", 32'(at_break), 32'd0);
        checkOutput("t4_break_to_halt_h", 32'(halted), 32'd1);
        applyStimulus(1'b1, 1'b0, 30);
        checkOutput("t4_resume_no_rebreak", 32'(at_break), 32'd0);
        checkOutput("t4_resume_running", 32'(halted), 32'd0);
        checkOutput("t4_resume_past_bp", 32'(pc > 32'h1C), 32'd1);
        applyStimulus(1'b0, 1'b0, 20);
        bp_en = 1'b0;

        // ---- 5: drop run mid-instruction, then reset mid-instruction ----
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(3);
        bi = imem_q.size();
        bc = cpu_q.size();
        c0 = cycle;
        run_sw = 1'b1;
        n = 0;
        while (imem_q.size() < bi + 2 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("t5_second_fetch_time", cycle, c0 + 4 + INST);
        tick(1);
        run_sw = 1'b0;
        tick(30);
        checkOutput("t5_fetches", imem_q.size() - bi, 32'd2);
        checkOutput("t5_commits", cpu_q.size() - bc, 32'd2);
        checkOutput("t5_commit_after_drop", cpu_q[bc + 1], c0 + 4 + INST + 3 * DIV);
        checkOutput("t5_count", inst_count, 32'd2);
        checkOutput("t5_halted", 32'(halted), 32'd1);
        bi = imem_q.size();
        bc = cpu_q.size();
        run_sw = 1'b1;
        n = 0;
        while (imem_q.size() < bi + 1 && n < 100) begin
            tick(1);
            n++;
        end
        tick(3);
        checkOutput("t5_running_before_rst", 32'(halted), 32'd0);
        sys_rst = 1'b1;
        #1;
        checkOutput("t5_rst_halted", 32'(halted), 32'd1);
        checkOutput("t5_rst_count", inst_count, 32'd0);
        checkOutput("t5_rst_at_break", 32'(at_break), 32'd0);
        checkOutput("t5_rst_pulses", 32'({imem_clk_en, dmem_clk_en, cpu_clk_en}), 32'd0);
        run_sw = 1'b0;
        tick(8);
        checkOutput("t5_no_commit_after_rst", cpu_q.size() - bc, 32'd0);
        sys_rst = 1'b0;
        tick(4);

        // ---- 6: counter wrap ----
        force dut.inst_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.inst_count_q;
        #1;
        checkOutput("t6_preload", inst_count, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 30);
        checkOutput("t6_wrap", inst_count, 32'h0000_0000);

        // ---- whole-run invariants ----
        checkOutput("no_overlapping_pulses", overlap_err, 32'd0);
        checkOutput("no_pulse_while_halted", halt_pulse_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
